// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DIV_W     = 16;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_W);

    // Iteration counter width for an n-bit divider (counts n-1 down to 0)
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nbit_subtractor.sv
// Combinational N-bit subtractor: o_diff = i_a - i_b, o_borrow set when i_b > i_a.
module nbit_subtractor #(
    parameter int unsigned N = 17
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_diff,
    output logic         o_borrow
);

    // Extend by one bit so the carry-out of the subtraction is the borrow
    always_comb begin
        {o_borrow, o_diff} = {1'b0, i_a} - {1'b0, i_b};
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock,
// valid/ready handshake on both sides.
// Optional macro DIV_ZERO_BYPASS_EN: a zero divisor skips the iterations
// and goes straight to DONE with the same result values.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned N = DIV_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int unsigned CW = cnt_width(N);

    state_e        r_state;
    state_e        w_next;
    logic [N-1:0]  r_q;
    logic [N-1:0]  r_d;
    logic [N-1:0]  r_r;
    logic [CW-1:0] r_cnt;
    logic          r_dbz;

    logic          w_accept;
    logic          w_last;
    logic          w_zero_div;
    logic [N:0]    w_trial_a;
    logic [N:0]    w_trial_b;
    logic [N:0]    w_diff;
    logic          w_borrow;
    logic          w_unused_diff_msb;

    assign w_accept   = in_valid && (r_state == IDLE);
    assign w_last     = (r_cnt == '0);
    assign w_zero_div = (divisor == '0);

    // Trial subtraction: shifted partial remainder minus divisor
    assign w_trial_a = {r_r, r_q[N-1]};
    assign w_trial_b = {1'b0, r_d};

    nbit_subtractor #(.N(N + 1)) u_sub (
        .i_a      (w_trial_a),
        .i_b      (w_trial_b),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

    // A successful trial leaves a value below the divisor, so its MSB is always zero
    assign w_unused_diff_msb = w_diff[N];

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
`ifdef DIV_ZERO_BYPASS_EN
                    w_next = w_zero_div ? DONE : RUN;
`else
                    w_next = RUN;
`endif
                end
            end
            RUN:     if (w_last) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the registered state only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture and one restoring iteration per RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= '0;
            r_d   <= '0;
            r_r   <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_q   <= dividend;
                        r_d   <= divisor;
                        r_r   <= '0;
                        r_cnt <= CW'(N - 1);
                        r_dbz <= w_zero_div;
`ifdef DIV_ZERO_BYPASS_EN
                        // Load the result the iterations would have produced
                        if (w_zero_div) begin
                            r_q <= '1;
                            r_r <= dividend;
                        end
`endif
                    end
                end
                RUN: begin
                    r_r   <= w_borrow ? w_trial_a[N-1:0] : w_diff[N-1:0];
                    r_q   <= {r_q[N-2:0], ~w_borrow};
                    r_cnt <= r_cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign quotient    = r_q;
    assign remainder   = r_r;
    assign div_by_zero = r_dbz;

endmodule
